// File: rtl/snake_if.sv
// Bus between the snake core and its neighbours: direction/grow/go requests
// in, pixel stream plus head/length/status out.
interface snake_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int LEN_W = 7
);
    logic             go;
    logic [3:0]       dir_in;
    logic             grow;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [2:0]       colour_out;
    logic             plotEn;
    logic [X_W-1:0]   head_x;
    logic [Y_W-1:0]   head_y;
    logic [LEN_W-1:0] length;
    logic             busy;
    logic             dead;
    logic             food_en;

    modport master (
        output go, dir_in, grow,
        input  x, y, colour_out, plotEn, head_x, head_y, length, busy, dead, food_en
    );
    modport slave (
        input  go, dir_in, grow,
        output x, y, colour_out, plotEn, head_x, head_y, length, busy, dead, food_en
    );
endinterface

// File: rtl/snake_engine.sv
// Snake game core: direction filter, move sequencer and ring-buffer body store.
// Define SNAKE_WRAP_EN to make the playfield toroidal instead of walls killing the snake.
module snake_engine #(
    parameter int       X_W      = 8,
    parameter int       Y_W      = 7,
    parameter int       GRID_W   = 160,
    parameter int       GRID_H   = 120,
    parameter int       MAX_LEN  = 64,
    parameter int       INIT_LEN = 4,
    parameter int       START_X  = 80,
    parameter int       START_Y  = 60,
    parameter logic [2:0] BODY_COL = 3'b010,
    parameter logic [2:0] BG_COL   = 3'b000
) (
    input  logic     clk,
    input  logic     rst,
    snake_if.slave   bus
);
    localparam int A_W   = $clog2(MAX_LEN);
    localparam int LEN_W = A_W + 1;
    localparam int D_W   = X_W + Y_W;
    localparam logic [3:0] DIR_U = 4'b1000;
    localparam logic [3:0] DIR_D = 4'b0100;
    localparam logic [3:0] DIR_L = 4'b0010;
    localparam logic [3:0] DIR_R = 4'b0001;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_CALC, S_CHECK, S_ERASE, S_DRAW, S_DONE, S_DEAD
    } state_t;

    state_t           r_state;
    logic [D_W-1:0]   r_mem [MAX_LEN];
    logic [D_W-1:0]   r_rd_data;
    logic [A_W-1:0]   r_head_ptr, r_tail_ptr;
    logic [LEN_W-1:0] r_idx, r_len;
    logic [X_W-1:0]   r_head_x, r_nxt_x, r_tail_x, r_x;
    logic [Y_W-1:0]   r_head_y, r_nxt_y, r_tail_y, r_y;
    logic [3:0]       r_dir, r_last_dir;
    logic [2:0]       r_col;
    logic             r_plot, r_food, r_dead, r_busy, r_grow_pend, r_eat;

    logic [3:0]       w_dir_ref, w_rev;
    logic             w_dir_ok, w_off, w_wall_hit, w_we;
    logic [X_W-1:0]   w_nxt_x, w_init_x;
    logic [Y_W-1:0]   w_nxt_y;
    logic [A_W-1:0]   w_rd_addr, w_wr_addr;
    logic [D_W-1:0]   w_wr_data;

    // A request made during CALC is judged against the direction being committed now.
    assign w_dir_ref = (r_state == S_CALC) ? r_dir : r_last_dir;
    assign w_rev     = {w_dir_ref[2], w_dir_ref[3], w_dir_ref[0], w_dir_ref[1]};
    assign w_dir_ok  = $onehot(bus.dir_in) && (bus.dir_in != w_rev);

    always_comb begin
        w_nxt_x = r_head_x;
        w_nxt_y = r_head_y;
        w_off   = 1'b0;
        case (r_dir)
            DIR_U: if (r_head_y == '0) begin
                       w_off = 1'b1; w_nxt_y = Y_W'(GRID_H - 1);
                   end else w_nxt_y = r_head_y - Y_W'(1);
            DIR_D: if (r_head_y == Y_W'(GRID_H - 1)) begin
                       w_off = 1'b1; w_nxt_y = '0;
                   end else w_nxt_y = r_head_y + Y_W'(1);
            DIR_L: if (r_head_x == '0) begin
                       w_off = 1'b1; w_nxt_x = X_W'(GRID_W - 1);
                   end else w_nxt_x = r_head_x - X_W'(1);
            default: if (r_head_x == X_W'(GRID_W - 1)) begin
                       w_off = 1'b1; w_nxt_x = '0;
                   end else w_nxt_x = r_head_x + X_W'(1);
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign w_wall_hit = 1'b0;
`else
    assign w_wall_hit = w_off;
`endif

    // Read is registered, so CALC prefetches the tail and CHECK runs one entry ahead.
    assign w_rd_addr = (r_state == S_CALC) ? r_tail_ptr
                                           : r_tail_ptr + r_idx[A_W-1:0] + A_W'(1);
    assign w_init_x  = X_W'(START_X) - X_W'(r_idx);
    assign w_we      = (r_state == S_INIT) || (r_state == S_DRAW);
    assign w_wr_addr = (r_state == S_INIT) ? A_W'(INIT_LEN - 1) - r_idx[A_W-1:0]
                                           : r_head_ptr + A_W'(1);
    assign w_wr_data = (r_state == S_INIT) ? {w_init_x, Y_W'(START_Y)} : {r_nxt_x, r_nxt_y};

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_wr_addr] <= w_wr_data;
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_INIT;
            r_x         <= '0;
            r_y         <= '0;
            r_col       <= '0;
            r_plot      <= 1'b0;
            r_food      <= 1'b0;
            r_dead      <= 1'b0;
            r_busy      <= 1'b1;
            r_dir       <= DIR_R;
            r_last_dir  <= DIR_R;
            r_grow_pend <= 1'b0;
            r_eat       <= 1'b0;
            r_head_x    <= X_W'(START_X);
            r_head_y    <= Y_W'(START_Y);
            r_nxt_x     <= '0;
            r_nxt_y     <= '0;
            r_tail_x    <= '0;
            r_tail_y    <= '0;
            r_len       <= LEN_W'(INIT_LEN);
            r_idx       <= '0;
            r_head_ptr  <= A_W'(INIT_LEN - 1);
            r_tail_ptr  <= '0;
        end else begin
            r_plot <= 1'b0;
            r_food <= 1'b0;
            if (w_dir_ok) r_dir <= bus.dir_in;
            if (bus.grow)                 r_grow_pend <= 1'b1;
            else if (r_state == S_CALC)   r_grow_pend <= 1'b0;

            case (r_state)
                S_INIT: begin
                    r_x    <= w_init_x;
                    r_y    <= Y_W'(START_Y);
                    r_col  <= BODY_COL;
                    r_plot <= 1'b1;
                    if (r_idx == LEN_W'(INIT_LEN - 1)) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + LEN_W'(1);
                    end
                end
                S_IDLE: if (bus.go) begin
                    r_busy  <= 1'b1;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_last_dir <= r_dir;
                    r_nxt_x    <= w_nxt_x;
                    r_nxt_y    <= w_nxt_y;
                    r_eat      <= r_grow_pend && (r_len < LEN_W'(MAX_LEN));
                    r_idx      <= '0;
                    if (w_wall_hit) begin
                        r_dead  <= 1'b1;
                        r_state <= S_DEAD;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_idx == '0) {r_tail_x, r_tail_y} <= r_rd_data;
                    // The tail vacates its cell this move unless the snake is growing.
                    if ((r_rd_data == {r_nxt_x, r_nxt_y}) && (r_eat || (r_idx != '0))) begin
                        r_dead  <= 1'b1;
                        r_state <= S_DEAD;
                    end else if (r_idx == r_len - LEN_W'(1)) begin
                        r_state <= r_eat ? S_DRAW : S_ERASE;
                    end else begin
                        r_idx <= r_idx + LEN_W'(1);
                    end
                end
                S_ERASE: begin
                    r_x        <= r_tail_x;
                    r_y        <= r_tail_y;
                    r_col      <= BG_COL;
                    r_plot     <= 1'b1;
                    r_tail_ptr <= r_tail_ptr + A_W'(1);
                    r_state    <= S_DRAW;
                end
                S_DRAW: begin
                    r_x        <= r_nxt_x;
                    r_y        <= r_nxt_y;
                    r_col      <= BODY_COL;
                    r_plot     <= 1'b1;
                    r_head_x   <= r_nxt_x;
                    r_head_y   <= r_nxt_y;
                    r_head_ptr <= r_head_ptr + A_W'(1);
                    if (r_eat) r_len <= r_len + LEN_W'(1);
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_food  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_DEAD: begin
                    r_dead <= 1'b1;
                    r_busy <= 1'b1;
                end
                default: r_state <= S_DEAD;
            endcase
        end
    end

    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.colour_out = r_col;
    assign bus.plotEn     = r_plot;
    assign bus.head_x     = r_head_x;
    assign bus.head_y     = r_head_y;
    assign bus.length     = r_len;
    assign bus.busy       = r_busy;
    assign bus.dead       = r_dead;
    assign bus.food_en    = r_food;
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: table of moves with hand-computed results,
// plus reset, dead-lock, saturation and wall sequences.
module tb_snake_engine;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] BG   = 3'b000;
    localparam logic [3:0] U = 4'b1000, D = 4'b0100, L = 4'b0010, R = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snake_if bus ();
    snake_engine dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int go_cyc = 0;
    int head_plot_cyc = -1;
    logic [17:0] plot_q [$];   // {x, y, colour}

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.plotEn) begin
            plot_q.push_back({bus.x, bus.y, bus.colour_out});
            if (bus.colour_out == BODY && head_plot_cyc < 0) head_plot_cyc = cyc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_move(input logic [3:0] d, input logic g, output int lat, output logic fe);
        int k;
        @(negedge clk);
        bus.dir_in = d;
        bus.grow   = g;
        @(negedge clk);
        bus.grow = 1'b0;
        bus.go   = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        plot_q.delete();
        head_plot_cyc = -1;
        go_cyc = cyc;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.busy && !bus.dead && k < 200);
        fe = bus.food_en;
        if (k >= 200) chk("move_timeout", 32'(k), 0);
        @(negedge clk);
        lat = (head_plot_cyc < 0) ? -1 : head_plot_cyc - go_cyc;
        $display("move dir=%b grow=%b head=(%0d,%0d) len=%0d dead=%b lat=%0d plots=%0d",
                 d, g, bus.head_x, bus.head_y, bus.length, bus.dead, lat, plot_q.size());
    endtask

    task automatic do_reset();
        int k;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 1);
        chk("rst_plotEn", 32'(bus.plotEn), 0);
        chk("rst_dead", 32'(bus.dead), 0);
        chk("rst_food_en", 32'(bus.food_en), 0);
        chk("rst_length", 32'(bus.length), 4);
        chk("rst_head_x", 32'(bus.head_x), 80);
        chk("rst_x", 32'(bus.x), 0);
        plot_q.delete();
        rst = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.busy && k < 50);
        @(negedge clk);
        chk("init_busy", 32'(bus.busy), 0);
        $display("reset released: init plots=%0d len=%0d", plot_q.size(), bus.length);
    endtask

    typedef struct {
        logic [3:0] dir;
        logic       grow;
        int         hx, hy, len;
        logic       erase;
        int         ex, ey;
        logic       dead;
        int         lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   lat;
        logic fe;
        int   n_pl;
        logic [17:0] pix;

        vecs[0] = '{R, 1'b0, 81, 60, 4, 1'b1, 77, 60, 1'b0, 7};
        vecs[1] = '{L, 1'b0, 82, 60, 4, 1'b1, 78, 60, 1'b0, 7};   // reversal rejected
        vecs[2] = '{R, 1'b1, 83, 60, 5, 1'b0,  0,  0, 1'b0, 6};   // grow: no erase
        vecs[3] = '{U, 1'b0, 83, 59, 5, 1'b1, 79, 60, 1'b0, 8};
        vecs[4] = '{L, 1'b0, 82, 59, 5, 1'b1, 80, 60, 1'b0, 8};
        vecs[5] = '{D, 1'b0, 82, 59, 5, 1'b0,  0,  0, 1'b1, -1};  // into body

        bus.go = 1'b0;
        bus.dir_in = 4'b0000;
        bus.grow = 1'b0;
        #12;

        do_reset();
        chk("init_plot_count", 32'(plot_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            pix = (i < plot_q.size()) ? plot_q[i] : 18'h0;
            chk("init_plot", 32'(pix), 32'({8'(80 - i), 7'd60, BODY}));
        end
        chk("init_length", 32'(bus.length), 4);

        for (int i = 0; i < 6; i++) begin
            do_move(vecs[i].dir, vecs[i].grow, lat, fe);
            chk("head_x", 32'(bus.head_x), 32'(vecs[i].hx));
            chk("head_y", 32'(bus.head_y), 32'(vecs[i].hy));
            chk("length", 32'(bus.length), 32'(vecs[i].len));
            chk("dead", 32'(bus.dead), 32'(vecs[i].dead));
            chk("food_en", 32'(fe), 32'(!vecs[i].dead));
            n_pl = vecs[i].dead ? 0 : (vecs[i].erase ? 2 : 1);
            chk("plot_count", 32'(plot_q.size()), 32'(n_pl));
            if (!vecs[i].dead) begin
                chk("latency", 32'(lat), 32'(vecs[i].lat));
                if (vecs[i].erase && plot_q.size() >= 1)
                    chk("erase_pix", 32'(plot_q[0]), 32'({8'(vecs[i].ex), 7'(vecs[i].ey), BG}));
                if (plot_q.size() >= 1)
                    chk("head_pix", 32'(plot_q[plot_q.size() - 1]),
                        32'({8'(vecs[i].hx), 7'(vecs[i].hy), BODY}));
            end
        end

        // Dead snake ignores go until reset
        plot_q.delete();
        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (20) @(negedge clk);
        chk("dead_no_plot", 32'(plot_q.size()), 0);
        chk("dead_sticky", 32'(bus.dead), 1);
        chk("dead_busy", 32'(bus.busy), 1);
        chk("dead_head_y", 32'(bus.head_y), 59);
        $display("go while dead: plots=%0d dead=%b", plot_q.size(), bus.dead);

        // Grow to saturation while heading right
        do_reset();
        chk("reset_clears_dead", 32'(bus.dead), 0);
        for (int i = 0; i < 60; i++) begin
            do_move(R, 1'b1, lat, fe);
            chk("grow_head_x", 32'(bus.head_x), 32'(81 + i));
        end
        chk("len_max", 32'(bus.length), 64);
        do_move(R, 1'b1, lat, fe);
        chk("len_saturated", 32'(bus.length), 64);
        chk("sat_erase_plots", 32'(plot_q.size()), 2);
        chk("sat_latency", 32'(lat), 67);
        for (int i = 0; i < 18; i++) do_move(R, 1'b0, lat, fe);
        chk("wall_head_x", 32'(bus.head_x), 159);
        chk("wall_alive", 32'(bus.dead), 0);
        do_move(R, 1'b0, lat, fe);
`ifdef SNAKE_WRAP_EN
        chk("wrap_head_x", 32'(bus.head_x), 0);
        chk("wrap_head_y", 32'(bus.head_y), 60);
        chk("wrap_alive", 32'(bus.dead), 0);
        chk("wrap_plots", 32'(plot_q.size()), 2);
`else
        chk("wall_dead", 32'(bus.dead), 1);
        chk("wall_no_plot", 32'(plot_q.size()), 0);
        chk("wall_head_hold", 32'(bus.head_x), 159);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
